dm_responder: RTL and testbench
===============================

// Module: dm_responder
// PURPOSE
//   Handshaked data-memory responder for the multi-cycle CPU datapath. The core
//   issues a load/store request and the block services it after a fixed latency.
//   It returns read data with a one-cycle Ack and flags misaligned or out-of-range
//   addresses. It sits between the core's memory stage and the word-organised
//   data RAM, and logs every store.
// PARAMETERS
//   DEPTH_LOG2  12  log2 of word count (4096 x 32-bit words, byte range 0x0000-0x3FFF)
//   LATENCY     2   clock edges from accept to access edge; legal range 1..15
// PORTS
//   Clk      in   1   system clock, all state on rising edge
//   Reset    in   1   synchronous, active-high; clears state and memory
//   Req      in   1   request valid; sampled only when Busy=0
//   ReqWe    in   1   1 = store, 0 = load
//   ReqAddr  in   32  byte address
//   ReqBE    in   4   byte enables for stores (bit i -> bits 8i+7:8i); ignored on loads
//   ReqWD    in   32  store data, byte-lane aligned
//   ReqPC    in   32  PC of the issuing instruction, used only for the store log
//   Busy     out  1   high while a request is in flight (WAIT state)
//   Ack      out  1   one-cycle completion pulse
//   RD       out  32  load data; qualified by Ack
//   Err      out  1   access error; qualified by Ack
// BEHAVIOUR
//   - Reset (highest priority, any state). State=IDLE; Busy=0, Ack=0, RD=0, Err=0;
//     counter=0; all memory words=0. An in-flight request is dropped: no write, no Ack.
//   - States:
//     IDLE: Busy=0, Ack=0.
//     WAIT: Busy=1, Ack=0.
//     RESP: Busy=0, Ack=1 for exactly one cycle.
//   - Accept. At an edge k with state in {IDLE, RESP} and Req=1:
//     register ReqWe, ReqAddr, ReqBE, ReqWD and ReqPC; counter=LATENCY-1; go to WAIT.
//     Otherwise IDLE/RESP -> IDLE. Req during WAIT is ignored and not queued.
//   - WAIT, counter!=0: counter decrements; no other change.
//   - WAIT, counter==0: perform the access at this edge, register RD/Err, go to RESP.
//     Ack is therefore high in the cycle after edge k+LATENCY.
//     Back-to-back Acks are LATENCY+1 cycles apart.
//   - Error check: Err=1 if addr[1:0]!=0 or addr[31:DEPTH_LOG2+2]!=0.
//     On error: no memory change, RD=0, no log.
//   - Word index = addr[DEPTH_LOG2+1:2].
//   - Load: RD = full stored word; Err=0.
//   - Store: each lane with BE=1 is replaced by the matching ReqWD lane; other lanes
//     are kept. RD=0, Err=0.
//     If BE!=0, print via $display "@%h: *%h <= %h" (PC, byte addr, merged word)
//     at the access edge. BE=0 is a legal store: memory unchanged, no log, Ack still given.
//   - RD and Err hold their value until the next completion; meaningful only while Ack=1.
//   - Store then load to the same word: the load returns the new data
//     (accesses are strictly serialised).
// TESTING
//   1. Reset, then load 0x00000000 with LATENCY=2 accepted at edge k ->
//      Busy=1 for 2 cycles, Ack=1 in cycle after edge k+2, RD=0, Err=0.
//   2. Store 0x00000010 WD=0x12345678 BE=4'b1111 PC=0x00003000, then load 0x10 ->
//      RD=0x12345678; log "@00003000: *00000010 <= 12345678".
//   3. Store 0x10 WD=0xAABBCCDD BE=4'b0011 onto 0x12345678, then load ->
//      RD=0x1234CCDD; log shows merged word 1234ccdd.
//   4. Store to 0x00000002, then load 0x00004000 -> both Ack with Err=1, RD=0.
//      Word 0 unchanged (still 0); no log lines.
//   5. Req held high with addresses 0x0, 0x4, 0x8 -> Ack pulses every LATENCY+1 cycles.
//      Each new request is accepted in its RESP cycle; Req inputs during WAIT have no effect.
//   6. Store 0x20 WD=0xFFFFFFFF, assert Reset for one cycle during WAIT ->
//      no Ack, no log; a later load of 0x20 returns RD=0, Err=0.

Source files
------------

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - fixed-latency handshaked data-memory responder with store log
module dm_responder #(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        ReqWe,
  input  logic [31:0] ReqAddr,
  input  logic [3:0]  ReqBE,
  input  logic [31:0] ReqWD,
  input  logic [31:0] ReqPC,
  output logic        Busy,
  output logic        Ack,
  output logic [31:0] RD,
  output logic        Err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int         WORDS    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [31:0] mem_q [WORDS];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept, access;

  logic        we_q;
  logic [31:0] addr_q, wd_q, pc_q;
  logic [3:0]  be_q;
  logic [31:0] rd_q;
  logic        err_q;

  logic [DEPTH_LOG2-1:0] idx;
  logic                  addr_err;
  logic [31:0]           merged;

  assign idx      = addr_q[DEPTH_LOG2+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:DEPTH_LOG2+2] != '0);
  assign RD       = rd_q;
  assign Err      = err_q;

  // Byte-lane merge of the captured store data over the currently stored word
  always_comb begin
    merged = mem_q[idx];
    for (int l = 0; l < 4; l++) begin
      if (be_q[l]) merged[8*l +: 8] = wd_q[8*l +: 8];
    end
  end

  // Next-state logic: accept in IDLE/RESP, count down in WAIT, access when the count expires
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    Busy    = 1'b0;
    Ack     = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        Ack = (state_q == S_RESP);
        if (Req) begin
          accept  = 1'b1;
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        Busy = 1'b1;
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latency counter registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture; the registered copy is what the access uses, so inputs during WAIT are ignored
  always_ff @(posedge Clk) begin
    if (Reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      be_q   <= '0;
      wd_q   <= '0;
      pc_q   <= '0;
    end else if (accept) begin
      we_q   <= ReqWe;
      addr_q <= ReqAddr;
      be_q   <= ReqBE;
      wd_q   <= ReqWD;
      pc_q   <= ReqPC;
    end
  end

  // Response registers; they hold until the next completed access
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_q  <= '0;
      err_q <= 1'b0;
    end else if (access) begin
      err_q <= addr_err;
      rd_q  <= (!addr_err && !we_q) ? mem_q[idx] : 32'd0;
    end
  end

  // Word memory with full clear on reset; each effective store is logged at its access edge
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else if (access && we_q && !addr_err && (be_q != 4'b0000)) begin
      mem_q[idx] <= merged;
      $display("@%h: *%h <= %h", pc_q, addr_q, merged);
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - directed self-checking bench for dm_responder
module tb_dm_responder;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Req = 1'b0;
  logic        ReqWe = 1'b0;
  logic [31:0] ReqAddr = '0;
  logic [3:0]  ReqBE = '0;
  logic [31:0] ReqWD = '0;
  logic [31:0] ReqPC = '0;
  logic        Busy, Ack, Err;
  logic [31:0] RD;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  dm_responder #(.DEPTH_LOG2(12), .LATENCY(2)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqWe(ReqWe), .ReqAddr(ReqAddr),
    .ReqBE(ReqBE), .ReqWD(ReqWD), .ReqPC(ReqPC),
    .Busy(Busy), .Ack(Ack), .RD(RD), .Err(Err)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, release Req after acceptance, wait (bounded) for Ack; returns in the RESP cycle
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] pc,
                        output logic [31:0] rd, output logic err, output int nbusy);
    int n;
    ReqWe = we; ReqAddr = addr; ReqBE = be; ReqWD = wd; ReqPC = pc; Req = 1'b1;
    @(posedge Clk); #1;
    Req = 1'b0;
    nbusy = 0;
    n = 0;
    while (!Ack && n < 40) begin
      if (Busy) nbusy++;
      @(posedge Clk); #1;
      n++;
    end
    chk("ack_seen", {31'd0, Ack}, 32'd1);
    rd  = RD;
    err = Err;
  endtask

  logic [31:0] rd;
  logic        err;
  int          nb;
  logic [31:0] addrs [3];
  logic [31:0] exps  [3];
  int          ack_cyc [3];
  int          n;
  logic        any_ack;

  initial begin
    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_ack",  {31'd0, Ack},  32'd0);
    chk("rst_rd",   RD, 32'd0);
    chk("rst_err",  {31'd0, Err},  32'd0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // 1: load word 0 after reset, latency 2
    do_req(1'b0, 32'h0, 4'h0, 32'h0, 32'h0, rd, err, nb);
    chk("t1_busy_cycles", 32'(nb), 32'd2);
    chk("t1_rd", rd, 32'd0);
    chk("t1_err", {31'd0, err}, 32'd0);
    @(posedge Clk); #1;
    chk("t1_ack_one_cycle", {31'd0, Ack}, 32'd0);

    // 2: full-word store then load
    do_req(1'b1, 32'h10, 4'hF, 32'h12345678, 32'h3000, rd, err, nb);
    chk("t2_st_rd", rd, 32'd0);
    chk("t2_st_err", {31'd0, err}, 32'd0);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, 32'h3004, rd, err, nb);
    chk("t2_ld_rd", rd, 32'h12345678);

    // 3: partial store merges low two lanes
    do_req(1'b1, 32'h10, 4'b0011, 32'hAABBCCDD, 32'h3008, rd, err, nb);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, 32'h300C, rd, err, nb);
    chk("t3_ld_rd", rd, 32'h1234CCDD);
    chk("t3_ld_err", {31'd0, err}, 32'd0);

    // 4: misaligned store and out-of-range load
    do_req(1'b1, 32'h2, 4'hF, 32'h55555555, 32'h3010, rd, err, nb);
    chk("t4_st_err", {31'd0, err}, 32'd1);
    chk("t4_st_rd", rd, 32'd0);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, 32'h3014, rd, err, nb);
    do_req(1'b0, 32'h4000, 4'h0, 32'h0, 32'h3018, rd, err, nb);
    chk("t4_ld_err", {31'd0, err}, 32'd1);
    chk("t4_ld_rd", rd, 32'd0);
    do_req(1'b0, 32'h0, 4'h0, 32'h0, 32'h301C, rd, err, nb);
    chk("t4_word0", rd, 32'd0);
    chk("t4_word0_err", {31'd0, err}, 32'd0);
    do_req(1'b0, 32'h3FFC, 4'h0, 32'h0, 32'h3020, rd, err, nb);
    chk("t4_top_word_err", {31'd0, err}, 32'd0);
    do_req(1'b1, 32'h14, 4'h0, 32'hCAFEF00D, 32'h3024, rd, err, nb);
    chk("t4_be0_err", {31'd0, err}, 32'd0);
    do_req(1'b0, 32'h14, 4'h0, 32'h0, 32'h3028, rd, err, nb);
    chk("t4_be0_unchanged", rd, 32'd0);

    // 5: Req held high, new request taken in each RESP cycle, WAIT inputs ignored
    do_req(1'b1, 32'h8, 4'hF, 32'h11223344, 32'h3030, rd, err, nb);
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
    exps[0]  = 32'h0; exps[1]  = 32'h0; exps[2]  = 32'h11223344;
    Req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ReqWe = 1'b0; ReqAddr = addrs[i]; ReqBE = 4'h0;
      @(posedge Clk); #1;
      ReqWe = 1'b1; ReqAddr = 32'h8; ReqWD = 32'hDEADBEEF; ReqBE = 4'hF;
      n = 0;
      while (!Ack && n < 20) begin
        @(posedge Clk); #1;
        n++;
      end
      chk("t5_ack", {31'd0, Ack}, 32'd1);
      ack_cyc[i] = cyc;
      chk("t5_rd", RD, exps[i]);
    end
    Req = 1'b0;
    chk("t5_gap01", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
    chk("t5_gap12", 32'(ack_cyc[2] - ack_cyc[1]), 32'd3);
    @(posedge Clk); #1;

    // 6: reset during WAIT drops the store
    ReqWe = 1'b1; ReqAddr = 32'h20; ReqWD = 32'hFFFFFFFF; ReqBE = 4'hF; ReqPC = 32'h3040;
    Req = 1'b1;
    @(posedge Clk); #1;
    Req = 1'b0;
    chk("t6_busy", {31'd0, Busy}, 32'd1);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    chk("t6_busy_cleared", {31'd0, Busy}, 32'd0);
    chk("t6_rd_cleared", RD, 32'd0);
    any_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      any_ack = any_ack | Ack;
      @(posedge Clk); #1;
    end
    chk("t6_no_ack", {31'd0, any_ack}, 32'd0);
    do_req(1'b0, 32'h20, 4'h0, 32'h0, 32'h3044, rd, err, nb);
    chk("t6_ld_rd", rd, 32'd0);
    chk("t6_ld_err", {31'd0, err}, 32'd0);
    do_req(1'b0, 32'h8, 4'h0, 32'h0, 32'h3048, rd, err, nb);
    chk("t6_mem_cleared", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
